// File: rtl/fft_pkg.sv
// Shared constants and state encodings for the radix-2 SDF FFT stages.
// FRAME is the number of samples in one frame, which is twice the delay-chain depth.
package fft_pkg;

  localparam int D     = 4;
  localparam int LOG2D = 2;
  localparam int FRAME = 2 * D;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STEADY = 2'd1,
    FLUSH  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/sdf_r2_stage_ctrl.sv
// Controller for one radix-2 SDF FFT stage with a D-deep delay chain: sample counter,
// fill/butterfly select, twiddle index, stream handshake and end-of-stream drain.
module sdf_r2_stage_ctrl #(
  parameter int D     = fft_pkg::D,
  parameter int LOG2D = fft_pkg::LOG2D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_first,
  output logic             m_last,
  output logic             dly_en,
  output logic             bf_sel,
  output logic [LOG2D-1:0] tw_idx,
  output logic             err
);
  import fft_pkg::*;

  localparam int CW = LOG2D + 1;

  stage_state_e     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LOG2D-1:0] fcnt_q, fcnt_d;
  logic             err_q, err_d;

  logic             adv;
  logic             s_ready_c, m_valid_c, m_first_c, m_last_c, bf_sel_c;
  logic [LOG2D-1:0] tw_idx_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fcnt_d    = fcnt_q;
    err_d     = 1'b0;
    adv       = 1'b0;
    s_ready_c = 1'b0;
    m_valid_c = 1'b0;
    m_first_c = 1'b0;
    m_last_c  = 1'b0;
    bf_sel_c  = 1'b0;
    tw_idx_c  = '0;
    unique case (state_q)
      FILL: begin
        s_ready_c = 1'b1;
        adv       = s_valid;
        if (adv) begin
          // Any s_last while the first half is still filling cannot close a frame.
          if (s_last) begin
            err_d = 1'b1;
            cnt_d = '0;
          end else if (cnt_q == CW'(D - 1)) begin
            state_d = STEADY;
            cnt_d   = CW'(D);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      STEADY: begin
        s_ready_c = m_ready;
        m_valid_c = s_valid;
        adv       = s_valid & m_ready;
        bf_sel_c  = cnt_q[LOG2D];
        m_first_c = (cnt_q == CW'(D));
        m_last_c  = (cnt_q == CW'(D - 1));
        if (!cnt_q[LOG2D]) tw_idx_c = cnt_q[LOG2D-1:0];
        if (adv) begin
          if (cnt_q == CW'(2 * D - 1)) begin
            cnt_d = '0;
            if (s_last) begin
              state_d = FLUSH;
              fcnt_d  = '0;
            end
          end else if (s_last) begin
            // Misplaced end of stream: drop the chain contents without draining.
            err_d   = 1'b1;
            state_d = FILL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FLUSH: begin
        m_valid_c = 1'b1;
        adv       = m_ready;
        tw_idx_c  = fcnt_q;
        m_last_c  = (fcnt_q == LOG2D'(D - 1));
        if (adv) begin
          if (fcnt_q == LOG2D'(D - 1)) begin
            state_d = FILL;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + LOG2D'(1);
          end
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
        fcnt_d  = '0;
      end
    endcase
  end

  // Outputs are forced low for as long as reset is held.
  assign s_ready = s_ready_c & ~rst;
  assign m_valid = m_valid_c & ~rst;
  assign m_first = m_first_c & ~rst;
  assign m_last  = m_last_c & ~rst;
  assign dly_en  = adv & ~rst;
  assign bf_sel  = bf_sel_c & ~rst;
  assign tw_idx  = rst ? '0 : tw_idx_c;
  assign err     = err_q & ~rst;

endmodule

// File: doc/sdf_r2_stage_ctrl.md
Name: sdf_r2_stage_ctrl

Overview:
Controller for one radix-2 single-path delay-feedback (SDF) FFT stage built around the 4-deep complex delay chain. It runs the stage's sample counter and drives the delay-chain write enable. It selects fill or butterfly mode for the stage datapath, produces the twiddle index, and runs the valid/ready handshake on both sides. After the final frame it drains the chain so the last differences leave the stage.

Parameters:
D, 4, delay-chain depth; power of two, equals half the frame length (frame = 2*D samples).
LOG2D, 2, log2(D); counter low-bit width.

Ports:
clk  in  1  stage clock
rst  in  1  reset, synchronous, active-high
s_valid  in  1  input sample valid
s_ready  out  1  stage accepts an input sample
s_last  in  1  marks the last input sample of the stream; legal only at cnt = 2*D-1
m_valid  out  1  stage output valid
m_ready  in  1  downstream accepts an output
m_first  out  1  first output beat of an output frame
m_last  out  1  last output beat of an output frame
dly_en  out  1  delay-chain write enable (w_en)
bf_sel  out  1  1 = butterfly phase (out = chain + x, chain <= chain - x); 0 = fill/drain phase (chain <= x, out = chain)
tw_idx  out  LOG2D  twiddle index for the current difference output
err  out  1  one-cycle pulse on an illegal s_last

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Registers:
  - state in {FILL, STEADY, FLUSH}
  - cnt, LOG2D+1 bits
  - fcnt, LOG2D bits
  - err_q
- On reset: state = FILL, cnt = 0, fcnt = 0, err_q = 0.
- While rst is high, all outputs are 0. One cycle after release, s_ready = 1.
- Handshake (all combinational from the registers and the handshake inputs):
  - FILL: s_ready = 1, m_valid = 0, adv = s_valid. m_ready is ignored.
  - STEADY: s_ready = m_ready, m_valid = s_valid, adv = s_valid & m_ready.
  - FLUSH: s_ready = 0, m_valid = 1, adv = m_ready.
- dly_en = adv. The chain shifts exactly once per accepted beat and never on stall cycles.
- bf_sel = (state == STEADY) & cnt[LOG2D].
- Outputs are combinational through the stage datapath. A sum leaves in the same beat as its input. A difference leaves D beats later, out of the chain.
- tw_idx:
  - STEADY with cnt[LOG2D] = 0: tw_idx = cnt[LOG2D-1:0].
  - FLUSH: tw_idx = fcnt.
  - Otherwise: tw_idx = 0.
- m_first = STEADY & cnt == D.
- m_last = (STEADY & cnt == D-1) | (FLUSH & fcnt == D-1).
- Transitions (only on adv):
  - FILL, cnt = D-1: go to STEADY, cnt = D. Otherwise cnt++.
  - FILL, s_last: err pulse, stay in FILL, cnt = 0.
  - STEADY, cnt = 2*D-1, s_last = 1: go to FLUSH, fcnt = 0, cnt = 0.
  - STEADY, cnt = 2*D-1, s_last = 0: stay in STEADY, cnt = 0. The next frame streams back to back; its fill phase emits the previous differences.
  - STEADY, s_last at any other cnt: err pulse, go to FILL, cnt = 0. Chain contents are discarded and not flushed; no m_last is produced.
  - STEADY, other cases: cnt++.
  - FLUSH, fcnt = D-1: go to FILL, fcnt = 0. Otherwise fcnt++.
- err: registered, high for exactly one cycle after the offending beat.
- Stall (adv = 0): all counters and state hold.
- rst mid-frame or mid-FLUSH: abort immediately. No drain, no m_last.
- Arithmetic: cnt wraps modulo 2*D. No datapath widths live in this block.

Decomposition:
- Shared package fft_pkg: D, LOG2D, the state encodings FILL/STEADY/FLUSH, and the frame length 2*D.
- The sample width `W stays in width.vh; this block does not use it.
- No sub-module. The counter and FSM are small enough to stay in one module.

Test Plan:
1. Reset, then 8 samples with s_last on sample 8 and m_ready = 1:
   - dly_en high for 8 input beats plus 4 flush beats.
   - m_valid high on samples 5-8 with bf_sel = 1; m_first on sample 5.
   - Flush beats have bf_sel = 0 and tw_idx = 0, 1, 2, 3.
   - m_last on flush beat 4; s_ready = 0 throughout FLUSH.
2. 16 samples back to back, s_last on sample 16:
   - No flush after sample 8.
   - m_first on samples 5 and 13; m_last on sample 12 and on the final flush beat.
   - tw_idx = 0..3 on samples 9-12.
3. m_ready low for 3 cycles at cnt = 6 in STEADY:
   - s_ready = 0 and dly_en = 0 for those 3 cycles; cnt stays 6.
   - Processing resumes correctly. The same stall during FILL has no effect on s_ready.
4. s_last on sample 6:
   - err high for exactly 1 cycle; state = FILL, cnt = 0.
   - No FLUSH and no m_last follow; the next 8-sample frame behaves as in scenario 1.
5. rst asserted during FLUSH at fcnt = 2:
   - All outputs 0 on the next cycle.
   - After release, s_ready = 1, state = FILL, and no m_last is emitted.
6. FILL with s_valid pattern 1,0,1,1,0,1:
   - dly_en pulses only on the four valid cycles.
   - STEADY is entered after the 4th accepted sample.
